// File: rtl/return_sequencer.sv
// Return-instruction sequencer: reads the saved RA from the stack, then writes back PC/RA/SP.
// Optional build macro RET_ALIGN_CHECK_EN rejects an odd return address before any memory read.
module return_sequencer #(
    parameter int unsigned MAX_WAIT = 255,
    parameter logic [15:0] SP_STEP  = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] ra_in,
    input  logic [15:0] sp_in,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] pc_out,
    output logic [15:0] ra_out,
    output logic [15:0] sp_out,
    output logic        pc_we,
    output logic        ra_we,
    output logic        sp_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, READ, COMMIT, ERROR} state_t;

    // Timeout fires on the unacknowledged cycle that brings the count to MAX_WAIT.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [15:0] ra_lat_q, ra_lat_d;
    logic [15:0] sp_lat_q, sp_lat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] rout_q, rout_d;
    logic [15:0] spout_q, spout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ra_lat_q <= '0;
            sp_lat_q <= '0;
            cnt_q    <= '0;
            pc_q     <= '0;
            rout_q   <= '0;
            spout_q  <= '0;
        end else begin
            state_q  <= state_d;
            ra_lat_q <= ra_lat_d;
            sp_lat_q <= sp_lat_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            rout_q   <= rout_d;
            spout_q  <= spout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ra_lat_d = ra_lat_q;
        sp_lat_d = sp_lat_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        rout_d   = rout_q;
        spout_d  = spout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_lat_d = ra_in;
                    sp_lat_d = sp_in;
                    cnt_d    = '0;
`ifdef RET_ALIGN_CHECK_EN
                    state_d  = ra_in[0] ? ERROR : READ;
`else
                    state_d  = READ;
`endif
                end
            end
            READ: begin
                if (mem_ack) begin
                    // Writeback values are registered here so they appear during COMMIT and hold after.
                    pc_d    = ra_lat_q;
                    rout_d  = mem_rdata;
                    spout_d = sp_lat_q + SP_STEP;
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == WAIT_LAST) state_d = ERROR;
                end
            end
            COMMIT:  state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req  = (state_q == READ);
    assign mem_addr = sp_lat_q;
    assign pc_out   = pc_q;
    assign ra_out   = rout_q;
    assign sp_out   = spout_q;
    assign pc_we    = (state_q == COMMIT);
    assign ra_we    = (state_q == COMMIT);
    assign sp_we    = (state_q == COMMIT);
    assign done     = (state_q == COMMIT);
    assign err      = (state_q == ERROR);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_return_sequencer.sv
// Bench for return_sequencer: cycle-timeline model checked every cycle plus directed literal checks.
module tb_return_sequencer;

    localparam int MAXW = 4;
`ifdef RET_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, mem_ack;
    logic [15:0] ra_in, sp_in, mem_rdata;
    logic        mem_req, pc_we, ra_we, sp_we, busy, done, err;
    logic [15:0] mem_addr, pc_out, ra_out, sp_out;

    int total = 0;
    int bad   = 0;

    return_sequencer #(.MAX_WAIT(MAXW), .SP_STEP(16'd2)) dut (
        .clk(clk), .rst(rst), .start(start), .ra_in(ra_in), .sp_in(sp_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pc_out(pc_out), .ra_out(ra_out), .sp_out(sp_out),
        .pc_we(pc_we), .ra_we(ra_we), .sp_we(sp_we),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction timeline model: a return accepted at cycle t0 requests memory in cycles
    // t0+1..t0+MAXW until acknowledged, commits the cycle after the ack, or errors after MAXW.
    bit          armed = 0, active = 0, acked = 0, abad = 0;
    int          n = 0, t0 = 0, ack_cyc = 0;
    logic [15:0] mra = '0, msp = '0;
    logic [15:0] e_pc = '0, e_ra = '0, e_sp = '0, e_addr = '0;

    always @(negedge clk) begin
        bit e_req, e_com, e_err;
        e_req = active && !abad && !acked && (n - t0) >= 1 && (n - t0) <= MAXW;
        e_com = active && acked && n == ack_cyc + 1;
        e_err = active && (abad ? (n == t0 + 1) : (!acked && n == t0 + MAXW + 1));
        if (armed) begin
            chk("m_strobes {req,pcwe,rawe,spwe,done,err,busy}",
                {9'd0, mem_req, pc_we, ra_we, sp_we, done, err, busy},
                {9'd0, e_req, e_com, e_com, e_com, e_com, e_err, active});
            chk("m_mem_addr", mem_addr, e_addr);
            chk("m_pc_out", pc_out, e_pc);
            chk("m_ra_out", ra_out, e_ra);
            chk("m_sp_out", sp_out, e_sp);
        end
        if (rst) begin
            active = 0; acked = 0; armed = 1;
            e_pc = '0; e_ra = '0; e_sp = '0; e_addr = '0;
        end else if (!active) begin
            if (start) begin
                active = 1; acked = 0; t0 = n;
                mra = ra_in; msp = sp_in; e_addr = sp_in;
                abad = ALIGN_EN && ra_in[0];
            end
        end else begin
            if (e_req && mem_ack) begin
                acked = 1; ack_cyc = n;
                e_pc = mra; e_ra = mem_rdata; e_sp = msp + 16'd2;
            end
            if (e_com || e_err) active = 0;
        end
        n++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] ra, input logic [15:0] sp);
        start = 1'b1; ra_in = ra; sp_in = sp;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_ack = 1'b0; ra_in = '0; sp_in = '0; mem_rdata = '0;
        step(); step();
        @(negedge clk);
        chk("reset_outputs", {pc_out ^ ra_out ^ sp_out ^ mem_addr}, 16'h0000);
        chk("reset_status", {10'd0, mem_req, busy, done, err, pc_we, sp_we}, 16'h0000);
        step();
        rst = 1'b0;
        step();

        // Immediate ack; a start during COMMIT must be ignored.
        go(16'h0104, 16'h7FF0);
        mem_ack = 1'b1; mem_rdata = 16'h0200;
        @(negedge clk);
        chk("A_req", {15'd0, mem_req}, 16'h0001);
        chk("A_addr", mem_addr, 16'h7FF0);
        step();
        mem_ack = 1'b0; start = 1'b1; ra_in = 16'hAAAA;
        @(negedge clk);
        chk("A_pc", pc_out, 16'h0104);
        chk("A_ra", ra_out, 16'h0200);
        chk("A_sp", sp_out, 16'h7FF2);
        chk("A_we_done", {12'd0, pc_we, ra_we, sp_we, done}, 16'h000F);
        step();
        start = 1'b0;
        @(negedge clk);
        chk("A_idle_after", {15'd0, busy}, 16'h0000);
        step();

        // Ack delayed three cycles: request held four cycles, done in cycle 5.
        go(16'h0220, 16'h7FF0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("B_req_wait", {15'd0, mem_req}, 16'h0001);
            step();
        end
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        @(negedge clk);
        chk("B_req_c4", {15'd0, mem_req}, 16'h0001);
        chk("B_addr_c4", mem_addr, 16'h7FF0);
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("B_done_c5", {15'd0, done}, 16'h0001);
        chk("B_ra", ra_out, 16'h1234);
        step();

        // SP wrap-around.
        go(16'h0300, 16'hFFFE);
        mem_ack = 1'b1; mem_rdata = 16'h0000;
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("C_sp_wrap", sp_out, 16'h0000);
        chk("C_done", {15'd0, done}, 16'h0001);
        step();

        // Timeout with MAX_WAIT=4; start during the ERROR cycle is ignored.
        go(16'h0400, 16'h1000);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("D_req_hold", {15'd0, mem_req}, 16'h0001);
            step();
        end
        start = 1'b1;
        @(negedge clk);
        chk("D_err", {15'd0, err}, 16'h0001);
        chk("D_no_we", {13'd0, pc_we, ra_we, sp_we}, 16'h0000);
        step();
        start = 1'b0;
        @(negedge clk);
        chk("D_after", {13'd0, busy, err, mem_req}, 16'h0000);
        step();

        // Reset during READ (with start, reset wins), then a late ack is ignored.
        go(16'h0500, 16'h2000);
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        @(negedge clk);
        chk("E_rst_idle", {14'd0, busy, mem_req}, 16'h0000);
        chk("E_rst_clear", pc_out | ra_out | sp_out | mem_addr, 16'h0000);
        step();
        @(negedge clk);
        chk("E_no_done", {12'd0, done, pc_we, ra_we, sp_we}, 16'h0000);
        step();
        mem_ack = 1'b0;
        go(16'h0010, 16'h3000);
        mem_ack = 1'b1; mem_rdata = 16'h0042;
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("E_recover_pc", pc_out, 16'h0010);
        chk("E_recover_done", {15'd0, done}, 16'h0001);
        step();

        // Odd return address.
        go(16'h0103, 16'h4000);
        mem_ack = 1'b1; mem_rdata = 16'h0055;
        @(negedge clk);
        if (ALIGN_EN) begin
            chk("F_align_err", {14'd0, err, mem_req}, 16'h0002);
        end else begin
            chk("F_req", {15'd0, mem_req}, 16'h0001);
        end
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        if (ALIGN_EN) begin
            chk("F_align_idle", {13'd0, busy, done, mem_req}, 16'h0000);
        end else begin
            chk("F_odd_pc", pc_out, 16'h0103);
            chk("F_done", {15'd0, done}, 16'h0001);
        end
        step(); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/return_sequencer.md
RETURN_SEQUENCER -- requirements
Module: return_sequencer

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: cycles mem_req may stay unacknowledged before a timeout (range 1..255).
REQ-002 SHALL have parameter SP_STEP, default 2: byte increment applied to SP on a completed return.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  return instruction issued, one-cycle pulse.
REQ-006 SHALL have port ra_in  input  16  current return address register value.
REQ-007 SHALL have port sp_in  input  16  current stack pointer, the address of the saved RA.
REQ-008 SHALL have port mem_req  output  1  memory read request.
REQ-009 SHALL have port mem_addr  output  16  memory read address.
REQ-010 SHALL have port mem_ack  input  1  read data valid, completes the request.
REQ-011 SHALL have port mem_rdata  input  16  read data, sampled only when mem_req and mem_ack are both high.
REQ-012 SHALL have ports pc_out/ra_out/sp_out  output  16 each  writeback values.
REQ-013 SHALL have ports pc_we/ra_we/sp_we  output  1 each  writeback strobes, one cycle.
REQ-014 SHALL have ports busy, done, err  output  1 each  status.

Function
REQ-015 SHALL implement the FSM states IDLE, READ, COMMIT and ERROR.
REQ-016 SHALL, in IDLE with start=1, latch ra_in and sp_in, clear the wait counter, and go to READ; busy=1 from the next cycle.
REQ-017 SHALL, in READ, drive mem_req=1 and mem_addr=latched SP, holding both stable until mem_ack.
REQ-018 SHALL, in READ with mem_ack=1, capture mem_rdata and go to COMMIT; an acknowledge on the first READ cycle is legal.
REQ-019 SHALL, in READ, increment the wait counter each cycle without mem_ack; when the count reaches MAX_WAIT, drop mem_req and go to ERROR.
REQ-020 SHALL, in COMMIT, for exactly one cycle, drive:
- pc_out=latched RA, pc_we=1;
- ra_out=captured rdata, ra_we=1;
- sp_out=latched SP+SP_STEP modulo 2^16 (0xFFFE+2 wraps to 0x0000), sp_we=1;
- done=1; then go to IDLE.
REQ-021 SHALL, in ERROR, assert err=1 for exactly one cycle with all write strobes low, then go to IDLE.
REQ-022 SHALL give a latency, with start at cycle 0 and no memory wait, of mem_req in cycle 1 and done in cycle 2; each wait cycle adds one cycle.
REQ-023 SHALL ignore start when not in IDLE, including in the COMMIT and ERROR cycles.
REQ-024 SHALL ignore mem_ack and mem_rdata when mem_req=0.
REQ-025 SHALL assert busy in READ, COMMIT and ERROR, and deassert it in IDLE.
REQ-026 SHALL hold all *_we, done, err and mem_req low outside their stated states; data outputs hold their last values.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, enter IDLE, clear the wait counter and the latched registers, and set every output to 0.
REQ-028 SHALL give rst priority over start and mem_ack in the same cycle.
REQ-029 SHALL, on reset mid-operation, drop mem_req at that edge, issue no writeback, and ignore any later mem_ack.

Configuration
REQ-030 SHALL, with RET_ALIGN_CHECK_EN defined, check the latched RA in IDLE on start: if ra_in[0]=1, go directly to ERROR with no memory request.
REQ-031 SHALL, without RET_ALIGN_CHECK_EN, perform no alignment check and use an odd RA unmodified.

Verification
REQ-032 SHALL cover: ra_in=0x0104, sp_in=0x7FF0, start, mem_ack in first READ cycle with rdata=0x0200 -> cycle 2 pc_out=0x0104, ra_out=0x0200, sp_out=0x7FF2, all *_we=1, done=1.
REQ-033 SHALL cover: mem_ack delayed by 3 cycles -> mem_req held 4 cycles with mem_addr=0x7FF0, done in cycle 5.
REQ-034 SHALL cover: sp_in=0xFFFE with a normal return -> sp_out=0x0000.
REQ-035 SHALL cover: MAX_WAIT=4 with mem_ack never asserted -> mem_req high for 4 cycles, err=1 for one cycle, no *_we asserted, busy=0 afterwards.
REQ-036 SHALL cover: rst raised during READ, then mem_ack raised -> no done and no *_we; a following start with ra_in=0x0010 completes normally.
REQ-037 SHALL cover: ra_in=0x0103 -> with RET_ALIGN_CHECK_EN, err=1 in cycle 1 and mem_req never asserted; without it, pc_out=0x0103 at done.
